// File: rtl/mux8way_arbiter_if.sv
// mux8way_arbiter_if: bundles the eight request channels and the single
// registered output channel of the 8-way word arbiter.
//   master : the surrounding system (drives requests and out_ready)
//   slave  : the arbiter itself
interface mux8way_arbiter_if #(
  parameter int WIDTH = 16
);
  logic [7:0]         in_valid;
  logic [8*WIDTH-1:0] in_data;
  logic [7:0]         in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [2:0]         out_sel;
  logic               out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/mux8way_arbiter.sv
// mux8way_arbiter: merges up to eight valid/ready word sources into one
// registered output channel, tagging each word with its source index.
// Build option: define MUX8WAY_RR_EN for round-robin arbitration driven by
// a "last granted" pointer; otherwise the lowest valid index always wins.
// in_ready is a combinational function of in_valid, out_ready and reset.
module mux8way_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  mux8way_arbiter_if.slave  bus
);

  logic             load;
  logic             gnt_any;
  logic [2:0]       gnt_idx;
  logic [2:0]       idx;
  logic [2:0]       start;
  logic             take;
  logic [WIDTH-1:0] gnt_word;

  logic             out_valid_p0;
  logic [WIDTH-1:0] out_data_p0;
  logic [2:0]       out_sel_p0;

`ifdef MUX8WAY_RR_EN
  logic [2:0]       last;

  // Round-robin pointer: remembers the most recently accepted source.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last <= 3'd7;
    end else if (take) begin
      last <= gnt_idx;
    end
  end

  assign start = last + 3'd1;
`else
  assign start = 3'd0;
`endif

  // The register can accept a word when empty or being drained this cycle.
  assign load = !out_valid_p0 || bus.out_ready;

  // Grant search: first valid source at or after start, wrapping upward.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = 3'd0;
    idx     = 3'd0;
    for (int k = 0; k < 8; k++) begin
      idx = start + 3'(k);
      if (!gnt_any && bus.in_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  assign take     = load && gnt_any && !reset;
  assign gnt_word = bus.in_data[32'(gnt_idx)*WIDTH +: WIDTH];

  // One-hot accept to the granted source; silent while reset is held.
  always_comb begin
    bus.in_ready = 8'h00;
    if (take) begin
      bus.in_ready[gnt_idx] = 1'b1;
    end
  end

  // ---- stage p0: output register ----
  // Output register: load granted word, empty on idle load, hold otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_p0 <= 1'b0;
      out_data_p0  <= '0;
      out_sel_p0   <= 3'd0;
    end else if (load) begin
      if (gnt_any) begin
        out_valid_p0 <= 1'b1;
        out_data_p0  <= gnt_word;
        out_sel_p0   <= gnt_idx;
      end else begin
        out_valid_p0 <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_p0;
  assign bus.out_data  = out_data_p0;
  assign bus.out_sel   = out_sel_p0;

endmodule

// File: tb/tb_mux8way_arbiter.sv
// tb_mux8way_arbiter: directed scenarios plus randomized traffic, compared
// every cycle against a transaction-level model of the arbiter.
module tb_mux8way_arbiter;

  logic clk = 1'b0;
  logic reset;

  mux8way_arbiter_if #(.WIDTH(16)) bus ();

  mux8way_arbiter #(.WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Model state
  logic        m_valid;
  logic [15:0] m_data;
  logic [2:0]  m_sel;
  int          m_last;
  logic [15:0] words [8];
  logic [7:0]  acc;
  logic [7:0]  pend;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int search_start();
`ifdef MUX8WAY_RR_EN
    return (m_last + 1) % 8;
`else
    return 0;
`endif
  endfunction

  function automatic int pick(input logic [7:0] v, input int st);
    for (int k = 0; k < 8; k++) begin
      if (v[(st + k) % 8]) return (st + k) % 8;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = 16'h0;
    m_sel   = 3'd0;
    m_last  = 7;
  endtask

  task automatic drive();
    for (int i = 0; i < 8; i++) bus.in_data[i*16 +: 16] = words[i];
  endtask

  task automatic check_out(input string tag);
    chk({tag, "_out_valid"}, {31'b0, bus.out_valid}, {31'b0, m_valid});
    chk({tag, "_out_data"},  {16'b0, bus.out_data},  {16'b0, m_data});
    chk({tag, "_out_sel"},   {29'b0, bus.out_sel},   {29'b0, m_sel});
  endtask

  // One clock: check in_ready before the edge, advance model, check outputs.
  task automatic cycle(input string tag);
    int         w;
    logic       ld;
    logic [7:0] er;
    drive();
    #1;
    ld = !m_valid || bus.out_ready;
    w  = pick(bus.in_valid, search_start());
    er = (ld && w >= 0 && !reset) ? 8'(1 << w) : 8'h00;
    chk({tag, "_in_ready"}, {24'b0, bus.in_ready}, {24'b0, er});
    acc = bus.in_valid & er;
    @(posedge clk);
    if (ld) begin
      if (w >= 0) begin
        m_valid = 1'b1;
        m_data  = words[w];
        m_sel   = 3'(w);
        m_last  = w;
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
    check_out(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1;
    check_out("rst");
    chk("rst_in_ready", {24'b0, bus.in_ready}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 8'h00;
    bus.out_ready = 1'b0;
    bus.in_data   = '0;
    for (int i = 0; i < 8; i++) words[i] = 16'h0;
    model_reset();
    #1;
    check_out("init");
    @(posedge clk);
    #1;
    do_reset();

    // Single source 5
    words[5] = 16'h1234;
    bus.in_valid  = 8'b0010_0000;
    bus.out_ready = 1'b1;
    cycle("single");
    chk("single_acc",  {24'b0, acc}, 32'h20);
    chk("single_data", {16'b0, bus.out_data}, 32'h1234);
    chk("single_sel",  {29'b0, bus.out_sel}, 32'd5);
    bus.in_valid = 8'h00;
    cycle("single_idle");
    chk("single_empty", {31'b0, bus.out_valid}, 32'd0);

    // Sweep with all sources valid after a fresh reset
    do_reset();
    for (int i = 0; i < 8; i++) words[i] = 16'hA000 + 16'(i);
    bus.in_valid  = 8'hFF;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      cycle("sweep");
`ifdef MUX8WAY_RR_EN
      chk("sweep_sel", {29'b0, bus.out_sel}, 32'(k % 8));
`else
      chk("sweep_sel", {29'b0, bus.out_sel}, 32'd0);
`endif
      chk("sweep_data", {16'b0, bus.out_data}, 32'h0000A000 + 32'(bus.out_sel));
    end

`ifdef MUX8WAY_RR_EN
    // Pointer skip: grant to 3, then sources 1 and 6
    bus.in_valid = 8'b0000_1000;
    cycle("skip3");
    chk("skip3_sel", {29'b0, bus.out_sel}, 32'd3);
    bus.in_valid = 8'b0100_0010;
    cycle("skip6");
    chk("skip6_sel", {29'b0, bus.out_sel}, 32'd6);
    bus.in_valid = 8'b0000_0010;
    cycle("skip1");
    chk("skip1_sel", {29'b0, bus.out_sel}, 32'd1);
`else
    // Fixed priority: 0 and 7 both valid
    bus.in_valid = 8'b1000_0001;
    for (int k = 0; k < 4; k++) begin
      cycle("fixed");
      chk("fixed_sel",    {29'b0, bus.out_sel}, 32'd0);
      chk("fixed_ready7", {31'b0, acc[7]}, 32'd0);
    end
`endif

    // Backpressure with sources 2 and 4
    bus.in_valid  = 8'h00;
    bus.out_ready = 1'b1;
    cycle("bp_drain");
    words[2] = 16'h2222;
    words[4] = 16'h4444;
    bus.in_valid  = 8'b0001_0100;
    bus.out_ready = 1'b0;
    cycle("bp_fill");
    words[2] = 16'h2223;
    for (int k = 0; k < 5; k++) begin
      cycle("bp_hold");
      chk("bp_hold_sel",  {29'b0, bus.out_sel}, 32'd2);
      chk("bp_hold_data", {16'b0, bus.out_data}, 32'h2222);
    end
    bus.out_ready = 1'b1;
    cycle("bp_release");
    chk("bp_release_acc", {31'b0, (acc != 8'h00)}, 32'd1);
    chk("bp_release_valid", {31'b0, bus.out_valid}, 32'd1);

    // Asynchronous reset mid-transfer, away from any clock edge
    bus.in_valid  = 8'hFF;
    bus.out_ready = 1'b0;
    cycle("pre_rst");
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_out("async_rst");
    chk("async_rst_in_ready", {24'b0, bus.in_ready}, 32'h0);
    #1;
    reset = 1'b0;
    words[0] = 16'h0A0A;
    words[5] = 16'h5A5A;
    bus.in_valid  = 8'b0010_0001;
    bus.out_ready = 1'b1;
    cycle("post_rst");
    chk("post_rst_sel", {29'b0, bus.out_sel}, 32'd0);

    // Randomized traffic obeying the source hold rule
    pend = bus.in_valid & ~acc;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 8; i++) begin
        if (!pend[i] && ($urandom_range(0, 3) == 0)) begin
          pend[i]  = 1'b1;
          words[i] = 16'($urandom);
        end
      end
      bus.in_valid  = pend;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      cycle("rand");
      pend = pend & ~acc;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
